spw_rx_credit_fifo: RTL and testbench

SPW_RX_CREDIT_FIFO -- requirements
Module: spw_rx_credit_fifo

---
 rtl/spw_rx_credit_fifo.sv | 140 ++++++++++++++
 tb/tb_spw_rx_credit_fifo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spw_rx_credit_fifo.sv
// SpaceWire receive FIFO with FCT credit management.
// Stores received N-Chars, tracks how much credit the far end holds, and asks the
// transmitter for an FCT whenever there is room for another chunk of credit.
module spw_rx_credit_fifo #(
   parameter int unsigned DWIDTH     = 9,
   parameter int unsigned AWIDTH     = 6,
   parameter int unsigned FCT_CHUNK  = 8,
   parameter int unsigned MAX_CREDIT = 56
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              link_en,
   input  logic              wr_en,
   input  logic [DWIDTH-1:0] data_in,
   input  logic              rd_en,
   output logic [DWIDTH-1:0] data_out,
   output logic              rd_valid,
   output logic              f_full,
   output logic              f_empty,
   output logic [AWIDTH:0]   level,
   output logic [AWIDTH:0]   credit,
   output logic              fct_req,
   input  logic              fct_ack,
   output logic              credit_error,
   output logic              overflow_error
);

   localparam int unsigned     DEPTH       = 1 << AWIDTH;
   localparam logic [AWIDTH:0] DepthW      = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH:0] ChunkW      = (AWIDTH+1)'(FCT_CHUNK);
   localparam logic [AWIDTH:0] MaxCreditW  = (AWIDTH+1)'(MAX_CREDIT);
   localparam logic [AWIDTH:0] GrantLimitW = (AWIDTH+1)'(DEPTH - FCT_CHUNK);
   localparam logic [AWIDTH:0] OneW        = (AWIDTH+1)'(1);
   localparam logic [AWIDTH-1:0] PtrOne    = AWIDTH'(1);

   typedef enum logic {StIdle, StReq} fct_state_e;

   logic [DWIDTH-1:0] mem [DEPTH];

   logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AWIDTH:0]   level_q, level_d, credit_q, credit_d, credit_sum;
   logic [DWIDTH-1:0] data_out_q, data_out_d;
   logic              rd_valid_q, rd_valid_d;
   logic              credit_error_q, credit_error_d;
   logic              overflow_q, overflow_d;
   fct_state_e        state_q, state_d;
   logic              wr_acc, rd_acc, ack_take, grant_ok;

   assign f_full         = (level_q == DepthW);
   assign f_empty        = (level_q == '0);
   assign level          = level_q;
   assign credit         = credit_q;
   assign data_out       = data_out_q;
   assign rd_valid       = rd_valid_q;
   assign credit_error   = credit_error_q;
   assign overflow_error = overflow_q;
   assign fct_req        = (state_q == StReq);

   // Next-state for pointers, level, credit, read port, error flags and the FCT FSM.
   always_comb begin
      wr_acc   = link_en & wr_en & ~f_full;
      rd_acc   = link_en & rd_en & ~f_empty;
      ack_take = (state_q == StReq) & fct_ack;
      // level + credit <= DEPTH - FCT_CHUNK is the free-space test without the
      // underflow that DEPTH - level - credit can hit after uncredited writes.
      grant_ok = (level_q + credit_q <= GrantLimitW) && (credit_q + ChunkW <= MaxCreditW);

      wr_ptr_d = wr_acc ? wr_ptr_q + PtrOne : wr_ptr_q;
      rd_ptr_d = rd_acc ? rd_ptr_q + PtrOne : rd_ptr_q;

      level_d = level_q;
      if (wr_acc && !rd_acc) begin
         level_d = level_q + OneW;
      end else if (rd_acc && !wr_acc) begin
         level_d = level_q - OneW;
      end

      // Credit granted by an FCT lands first, then the write consumes one (floor 0).
      credit_sum = ack_take ? credit_q + ChunkW : credit_q;
      credit_d   = credit_sum;
      if (wr_acc && credit_sum != '0) begin
         credit_d = credit_sum - OneW;
      end

      credit_error_d = credit_error_q | (wr_acc & (credit_q == '0));
      overflow_d     = link_en & wr_en & f_full;
      rd_valid_d     = rd_acc;
      data_out_d     = rd_acc ? mem[rd_ptr_q] : data_out_q;

      state_d = state_q;
      unique case (state_q)
         StIdle:  if (grant_ok) state_d = StReq;
         StReq:   if (fct_ack) state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Link not running: flush everything and drop any outstanding FCT request.
      if (!link_en) begin
         wr_ptr_d       = '0;
         rd_ptr_d       = '0;
         level_d        = '0;
         credit_d       = '0;
         credit_error_d = 1'b0;
         state_d        = StIdle;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         level_q        <= '0;
         credit_q       <= '0;
         data_out_q     <= '0;
         rd_valid_q     <= 1'b0;
         credit_error_q <= 1'b0;
         overflow_q     <= 1'b0;
         state_q        <= StIdle;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         level_q        <= level_d;
         credit_q       <= credit_d;
         data_out_q     <= data_out_d;
         rd_valid_q     <= rd_valid_d;
         credit_error_q <= credit_error_d;
         overflow_q     <= overflow_d;
         state_q        <= state_d;
      end
   end

   // Storage array; contents are don't-care after reset.
   always_ff @(posedge clock) begin
      if (wr_acc) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

endmodule

// File: tb/tb_spw_rx_credit_fifo.sv
// Self-checking bench for spw_rx_credit_fifo: directed credit/FIFO scenarios with a
// data scoreboard checking every word that comes out of the read port.
module tb_spw_rx_credit_fifo;

   logic       clock;
   logic       reset;
   logic       link_en;
   logic       wr_en;
   logic [8:0] data_in;
   logic       rd_en;
   logic [8:0] data_out;
   logic       rd_valid;
   logic       f_full;
   logic       f_empty;
   logic [6:0] level;
   logic [6:0] credit;
   logic       fct_req;
   logic       fct_ack;
   logic       credit_error;
   logic       overflow_error;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [8:0] exp_q[$];
   logic [8:0] mon_exp;
   int         hs;
   bit         seen;

   spw_rx_credit_fifo #(
      .DWIDTH     (9),
      .AWIDTH     (6),
      .FCT_CHUNK  (8),
      .MAX_CREDIT (56)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .link_en        (link_en),
      .wr_en          (wr_en),
      .data_in        (data_in),
      .rd_en          (rd_en),
      .data_out       (data_out),
      .rd_valid       (rd_valid),
      .f_full         (f_full),
      .f_empty        (f_empty),
      .level          (level),
      .credit         (credit),
      .fct_req        (fct_req),
      .fct_ack        (fct_ack),
      .credit_error   (credit_error),
      .overflow_error (overflow_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_req(input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (fct_req) begin
            found = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // Acknowledge a pending request two cycles after it was seen.
   task automatic ack_req();
      repeat (2) tick();
      fct_ack = 1'b1;
      tick();
      fct_ack = 1'b0;
   endtask

   task automatic write_words(input int n);
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         data_in = 9'($urandom_range(1, 511));
         exp_q.push_back(data_in);
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic read_words(input int n);
      rd_en = 1'b1;
      repeat (n) tick();
      rd_en = 1'b0;
   endtask

   // Scoreboard: every read result must match the oldest accepted write.
   always @(posedge clock) begin
      #1;
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            check_val("rd_unexpected", 32'(rd_valid), 0);
         end else begin
            mon_exp = exp_q.pop_front();
            check_val("rd_data", 32'(data_out), 32'(mon_exp));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      reset   = 1'b1;
      link_en = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      data_in = '0;
      fct_ack = 1'b0;
      repeat (3) tick();

      // Reset state.
      check_val("rst_level", 32'(level), 0);
      check_val("rst_credit", 32'(credit), 0);
      check_val("rst_empty", 32'(f_empty), 1);
      check_val("rst_full", 32'(f_full), 0);
      check_val("rst_fct_req", 32'(fct_req), 0);
      check_val("rst_rd_valid", 32'(rd_valid), 0);
      check_val("rst_cred_err", 32'(credit_error), 0);
      check_val("rst_ovf", 32'(overflow_error), 0);
      check_val("rst_data_out", 32'(data_out), 0);
      link_en = 1'b1;
      tick();
      check_val("rst_hold_req", 32'(fct_req), 0);
      reset = 1'b0;

      // Initial credit build-up: seven FCTs, then no more.
      hs = 0;
      for (int k = 0; k < 10; k++) begin
         wait_req(20, seen);
         if (!seen) break;
         ack_req();
         hs++;
      end
      check_val("init_handshakes", 32'(hs), 7);
      check_val("init_credit", 32'(credit), 56);
      check_val("init_no_8th_req", 32'(fct_req), 0);

      // Eight words consume a chunk and trigger one new FCT.
      write_words(8);
      check_val("w8_credit", 32'(credit), 48);
      check_val("w8_level", 32'(level), 8);
      wait_req(5, seen);
      check_val("w8_req_seen", 32'(seen), 1);
      ack_req();
      check_val("w8_ack_credit", 32'(credit), 56);
      wait_req(10, seen);
      check_val("w8_no_2nd_req", 32'(seen), 0);

      // Drain, plus one read at empty that must be ignored.
      read_words(9);
      check_val("drain_level", 32'(level), 0);
      check_val("drain_empty", 32'(f_empty), 1);
      check_val("rd_at_empty", 32'(rd_valid), 0);
      check_val("drain_q", 32'(exp_q.size()), 0);

      // Exhaust credit, then one uncredited write.
      write_words(56);
      check_val("w56_credit", 32'(credit), 0);
      check_val("w56_cred_err", 32'(credit_error), 0);
      check_val("w56_level", 32'(level), 56);
      write_words(1);
      check_val("w57_credit", 32'(credit), 0);
      check_val("w57_cred_err", 32'(credit_error), 1);
      check_val("w57_level", 32'(level), 57);
      check_val("w57_full", 32'(f_full), 0);

      // Fill, then simultaneous write and read at full.
      write_words(7);
      check_val("fill_level", 32'(level), 64);
      check_val("fill_full", 32'(f_full), 1);
      check_val("fill_empty", 32'(f_empty), 0);
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      data_in = 9'($urandom_range(1, 511));
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      check_val("ovf_pulse", 32'(overflow_error), 1);
      check_val("ovf_level", 32'(level), 63);
      check_val("ovf_full", 32'(f_full), 0);
      check_val("ovf_credit", 32'(credit), 0);
      tick();
      check_val("ovf_one_cycle", 32'(overflow_error), 0);

      // Link drop with data stored and a request pending.
      read_words(43);
      check_val("pre_drop_level", 32'(level), 20);
      check_val("pre_drop_req", 32'(fct_req), 1);
      link_en = 1'b0;
      wr_en   = 1'b1;
      data_in = 9'h155;
      tick();
      wr_en = 1'b0;
      exp_q.delete();
      check_val("drop_level", 32'(level), 0);
      check_val("drop_empty", 32'(f_empty), 1);
      check_val("drop_credit", 32'(credit), 0);
      check_val("drop_req", 32'(fct_req), 0);
      check_val("drop_cred_err", 32'(credit_error), 0);
      link_en = 1'b1;

      // Ack and write in the same cycle at credit 48.
      hs = 0;
      for (int k = 0; k < 6; k++) begin
         wait_req(20, seen);
         if (!seen) break;
         ack_req();
         hs++;
      end
      check_val("relink_handshakes", 32'(hs), 6);
      wait_req(10, seen);
      check_val("req7_seen", 32'(seen), 1);
      check_val("req7_credit", 32'(credit), 48);
      repeat (2) tick();
      fct_ack = 1'b1;
      wr_en   = 1'b1;
      data_in = 9'($urandom_range(1, 511));
      exp_q.push_back(data_in);
      tick();
      fct_ack = 1'b0;
      wr_en   = 1'b0;
      check_val("ackwr_credit", 32'(credit), 55);
      check_val("ackwr_level", 32'(level), 1);
      check_val("ackwr_req", 32'(fct_req), 0);

      // Ack while idle is ignored.
      fct_ack = 1'b1;
      tick();
      fct_ack = 1'b0;
      tick();
      check_val("idle_ack_credit", 32'(credit), 55);
      check_val("idle_ack_req", 32'(fct_req), 0);
      read_words(1);
      tick();
      check_val("last_q", 32'(exp_q.size()), 0);

      // Asynchronous reset mid-request.
      link_en = 1'b0;
      tick();
      link_en = 1'b1;
      tick();
      wait_req(5, seen);
      check_val("areset_req_seen", 32'(seen), 1);
      #3;
      reset = 1'b1;
      #1;
      check_val("areset_req", 32'(fct_req), 0);
      check_val("areset_credit", 32'(credit), 0);
      check_val("areset_data_out", 32'(data_out), 0);
      check_val("areset_empty", 32'(f_empty), 1);
      exp_q.delete();
      repeat (2) tick();
      reset = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
